hilo_unit: RTL and testbench

Sequencer and architectural HI/LO register file between the multicycle control unit and the iterative divide/multiply units. It accepts a one-cycle divide or multiply request and holds the unit's enable for the fixed iteration time. It then captures the unit's 64-bit result into HI/LO, or aborts on divide-by-zero. It stalls the control unit via `busy`, signals completion with `done`, and serves mthi/mtlo writes plus continuous HI/LO reads for mfhi/mflo.

---
 rtl/hilo_unit.sv | 150 +++++++++++++++
 tb/tb_hilo_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// hilo_unit
//   Sequencer plus architectural HI/LO register file sitting between the
//   multicycle control unit and the iterative divide/multiply units.
//   A one-cycle div_req/mult_req in IDLE starts an operation; the matching
//   unit enable is held for LATENCY+1 edges (first edge is the unit's clear
//   step), after which the 64-bit result is captured into HI/LO and done
//   pulses. A divide whose divider reports divide-by-zero on the second
//   enabled edge is aborted with a div_zero_exc pulse and HI/LO untouched.
//   mthi/mtlo writes are honoured only while idle.
//
// Parameters
//   DIV_LATENCY   enabled edges until divider HI/LO are valid (<= 62)
//   MULT_LATENCY  enabled edges until multiplier HI/LO are valid (<= 62)
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   div_req, mult_req     start requests (divide wins if both)
//   div_zero              divider's divide-by-zero flag
//   div_hi, div_lo        divider remainder / quotient
//   mult_hi, mult_lo      multiplier product high / low
//   mthi, mtlo, wdata     HI / LO write strobes and data
//   div_ctrl, mult_ctrl   unit enables (decoded from state)
//   busy                  operation in flight, control unit stalls
//   done                  one-cycle pulse after a successful capture
//   div_zero_exc          one-cycle pulse on an aborted divide
//   hi, lo                architectural HI / LO
module hilo_unit #(
  parameter int unsigned DIV_LATENCY  = 35,
  parameter int unsigned MULT_LATENCY = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_req,
  input  logic        mult_req,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        div_ctrl,
  output logic        mult_ctrl,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    MULT_RUN = 2'd2
  } state_e;

  localparam logic [5:0] DIV_LAST  = 6'(DIV_LATENCY);
  localparam logic [5:0] MULT_LAST = 6'(MULT_LATENCY);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        done_q,  done_d;
  logic        exc_q,   exc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    exc_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Writes and a request in the same cycle both take effect; the
        // later capture simply overwrites whatever was written here.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (div_req)       state_d = DIV_RUN;
        else if (mult_req) state_d = MULT_RUN;
      end

      DIV_RUN: begin
        cnt_d = cnt_q + 6'd1;
        // The divider flags a zero divisor once its clear step is done,
        // i.e. on the second enabled edge; abort takes priority.
        if ((cnt_q == 6'd1) && div_zero) begin
          state_d = IDLE;
          cnt_d   = '0;
          exc_d   = 1'b1;
        end else if (cnt_q == DIV_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = div_hi;
          lo_d    = div_lo;
          done_d  = 1'b1;
        end
      end

      MULT_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == MULT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

  // Enables and busy are decoded from state so they drop the moment reset
  // forces IDLE.
  assign div_ctrl     = (state_q == DIV_RUN);
  assign mult_ctrl    = (state_q == MULT_RUN);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign div_zero_exc = exc_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit. Divider and multiplier are modelled by
// small stubs whose HI/LO only become valid after LATENCY enabled edges,
// so an early capture picks up a recognisable junk value.
module tb_hilo_unit;

  localparam int unsigned DIV_LAT  = 35;
  localparam int unsigned MULT_LAT = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_req, mult_req, div_zero;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        div_ctrl, mult_ctrl, busy, done, div_zero_exc;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  // stub result values set by each test
  logic [31:0] d_rem, d_quo, m_hi, m_lo;
  int dcnt, mcnt;

  always #5 clk = ~clk;

  hilo_unit #(.DIV_LATENCY(DIV_LAT), .MULT_LATENCY(MULT_LAT)) dut (
    .clk(clk), .reset(reset),
    .div_req(div_req), .mult_req(mult_req), .div_zero(div_zero),
    .div_hi(div_hi), .div_lo(div_lo), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .div_ctrl(div_ctrl), .mult_ctrl(mult_ctrl), .busy(busy), .done(done),
    .div_zero_exc(div_zero_exc), .hi(hi), .lo(lo)
  );

  always @(posedge clk or posedge reset) begin
    if (reset)          dcnt <= 0;
    else if (!div_ctrl) dcnt <= 0;
    else if (dcnt < 63) dcnt <= dcnt + 1;
  end
  always @(posedge clk or posedge reset) begin
    if (reset)           mcnt <= 0;
    else if (!mult_ctrl) mcnt <= 0;
    else if (mcnt < 63)  mcnt <= mcnt + 1;
  end
  assign div_hi  = (dcnt >= DIV_LAT)  ? d_rem : 32'hBADD_0001;
  assign div_lo  = (dcnt >= DIV_LAT)  ? d_quo : 32'hBADD_0002;
  assign mult_hi = (mcnt >= MULT_LAT) ? m_hi  : 32'hBADD_0003;
  assign mult_lo = (mcnt >= MULT_LAT) ? m_lo  : 32'hBADD_0004;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue a request now (caller sits 1 time unit after an edge), then
  // sample until busy falls. Returns on the capture edge + 1.
  task automatic run_op(input logic dreq, input logic mreq,
                        output int busy_n, output int ctrl_n, output int other_n);
    div_req  = dreq;
    mult_req = mreq;
    step();
    div_req  = 1'b0;
    mult_req = 1'b0;
    busy_n = 0; ctrl_n = 0; other_n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      busy_n++;
      if (dreq ? div_ctrl : mult_ctrl) ctrl_n++;
      if (dreq ? mult_ctrl : div_ctrl) other_n++;
      step();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    div_req = 0; mult_req = 0; div_zero = 0; mthi = 0; mtlo = 0; wdata = '0;
    d_rem = '0; d_quo = '0; m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({div_ctrl, mult_ctrl, busy, done, div_zero_exc} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {div_ctrl, mult_ctrl, busy, done, div_zero_exc});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h expected 0_0", hi, lo);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_div(input string name, input logic [31:0] rem, input logic [31:0] quo);
    int b, c, o;
    d_rem = rem; d_quo = quo;
    run_op(1'b1, 1'b0, b, c, o);
    checks++;
    if (b != 36) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 36", name, b); end
    checks++;
    if (c != 36) begin errors++; $display("FAIL %s_div_ctrl_edges: got %0d expected 36", name, c); end
    checks++;
    if (o != 0) begin errors++; $display("FAIL %s_mult_ctrl: got %0d expected 0", name, o); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", name, done); end
    checks++;
    if (hi !== rem || lo !== quo) begin
      errors++;
      $display("FAIL %s_hilo: got %h_%h expected %h_%h", name, hi, lo, rem, quo);
    end
    step();
    checks++;
    if (done !== 1'b0 || hi !== rem) begin
      errors++;
      $display("FAIL %s_done_pulse: got done=%b hi=%h expected done=0 hi=%h", name, done, hi, rem);
    end
  endtask

  task automatic test_div_zero;
    mthi = 1; mtlo = 1; wdata = 32'hAAAA5555;
    step();
    mthi = 0; mtlo = 0;
    checks++;
    if (hi !== 32'hAAAA5555 || lo !== 32'hAAAA5555) begin
      errors++;
      $display("FAIL dz_preload: got %h_%h expected aaaa5555_aaaa5555", hi, lo);
    end
    div_zero = 1; d_rem = 32'h1111_1111; d_quo = 32'h2222_2222;
    div_req = 1;
    step();
    div_req = 0;
    checks++;
    if (busy !== 1'b1 || div_zero_exc !== 1'b0) begin
      errors++; $display("FAIL dz_e0: got busy=%b exc=%b expected busy=1 exc=0", busy, div_zero_exc);
    end
    step();
    checks++;
    if (busy !== 1'b1 || div_zero_exc !== 1'b0) begin
      errors++; $display("FAIL dz_e1: got busy=%b exc=%b expected busy=1 exc=0", busy, div_zero_exc);
    end
    step();
    checks++;
    if (busy !== 1'b0 || div_zero_exc !== 1'b1 || done !== 1'b0 || div_ctrl !== 1'b0) begin
      errors++;
      $display("FAIL dz_e2: got busy=%b exc=%b done=%b div_ctrl=%b expected 0 1 0 0", busy, div_zero_exc, done, div_ctrl);
    end
    checks++;
    if (hi !== 32'hAAAA5555 || lo !== 32'hAAAA5555) begin
      errors++; $display("FAIL dz_hilo_kept: got %h_%h expected aaaa5555_aaaa5555", hi, lo);
    end
    step();
    checks++;
    if (div_zero_exc !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL dz_pulse: got exc=%b done=%b expected 0 0", div_zero_exc, done);
    end
    div_zero = 0;
  endtask

  task automatic test_mult;
    int b, c, o;
    m_hi = 32'h1; m_lo = 32'h2;
    div_zero = 1;  // must not matter for a multiply
    run_op(1'b0, 1'b1, b, c, o);
    div_zero = 0;
    checks++;
    if (b != 34 || c != 34) begin
      errors++; $display("FAIL mult_timing: got busy=%0d ctrl=%0d expected 34 34", b, c);
    end
    checks++;
    if (o != 0) begin errors++; $display("FAIL mult_div_ctrl: got %0d expected 0", o); end
    checks++;
    if (done !== 1'b1 || div_zero_exc !== 1'b0 || hi !== 32'h1 || lo !== 32'h2) begin
      errors++;
      $display("FAIL mult_capture: got done=%b exc=%b hi=%h lo=%h expected 1 0 00000001 00000002", done, div_zero_exc, hi, lo);
    end
  endtask

  task automatic test_simultaneous;
    int b, c, o;
    d_rem = 32'h5; d_quo = 32'h6; m_hi = 32'h77; m_lo = 32'h88;
    run_op(1'b1, 1'b1, b, c, o);
    checks++;
    if (o != 0 || c != 36) begin
      errors++; $display("FAIL simul_ctrl: got mult_edges=%0d div_edges=%0d expected 0 36", o, c);
    end
    checks++;
    if (hi !== 32'h5 || lo !== 32'h6) begin
      errors++; $display("FAIL simul_hilo: got %h_%h expected 00000005_00000006", hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int b, c, o;
    d_rem = 32'hA; d_quo = 32'hB; m_hi = 32'hC; m_lo = 32'hD;
    run_op(1'b1, 1'b0, b, c, o);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done); end
    // new request issued during the done cycle
    run_op(1'b0, 1'b1, b, c, o);
    checks++;
    if (b != 34 || hi !== 32'hC || lo !== 32'hD) begin
      errors++; $display("FAIL b2b_second: got busy=%0d hi=%h lo=%h expected 34 0000000c 0000000d", b, hi, lo);
    end
    step();
  endtask

  task automatic test_reset_mid;
    int b, c, o;
    d_rem = 32'h99; d_quo = 32'h98;
    div_req = 1;
    step();
    div_req = 0;
    repeat (10) step();
    checks++;
    if (busy !== 1'b1 || div_ctrl !== 1'b1 || hi !== 32'hC) begin
      errors++; $display("FAIL rst_mid_pre: got busy=%b div_ctrl=%b hi=%h expected 1 1 0000000c", busy, div_ctrl, hi);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({div_ctrl, mult_ctrl, busy, done, div_zero_exc} !== 5'b0 || {hi, lo} !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got ctrl=%b hi=%h lo=%h expected 00000 0 0",
               {div_ctrl, mult_ctrl, busy, done, div_zero_exc}, hi, lo);
    end
    step();
    reset = 1'b0;
    step();
    d_rem = 32'h0; d_quo = 32'h3;
    run_op(1'b1, 1'b0, b, c, o);
    checks++;
    if (b != 36 || done !== 1'b1 || hi !== 32'h0 || lo !== 32'h3) begin
      errors++; $display("FAIL rst_mid_next: got busy=%0d done=%b hi=%h lo=%h expected 36 1 0 3", b, done, hi, lo);
    end
    step();
  endtask

  task automatic test_write_busy;
    d_rem = 32'h11; d_quo = 32'h22;
    div_req = 1;
    step();
    div_req = 0;
    repeat (3) step();
    mthi = 1; mtlo = 1; wdata = 32'h12345678;
    step();
    mthi = 0; mtlo = 0;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h3 || busy !== 1'b1) begin
      errors++; $display("FAIL wr_busy_ignored: got hi=%h lo=%h busy=%b expected 0 3 1", hi, lo, busy);
    end
    for (int i = 0; i < 100 && busy; i++) step();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL wr_busy_capture: got busy=%b hi=%h lo=%h expected 0 11 22", busy, hi, lo);
    end
    step();
  endtask

  task automatic test_write_idle;
    mthi = 1; mtlo = 1; wdata = 32'hDEADBEEF;
    step();
    mthi = 0; mtlo = 0;
    checks++;
    if (hi !== 32'hDEADBEEF || lo !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_both: got %h_%h expected deadbeef_deadbeef", hi, lo);
    end
    mtlo = 1; wdata = 32'hCAFE0001;
    step();
    mtlo = 0;
    checks++;
    if (hi !== 32'hDEADBEEF || lo !== 32'hCAFE0001) begin
      errors++; $display("FAIL wr_lo_only: got %h_%h expected deadbeef_cafe0001", hi, lo);
    end
    mthi = 1; wdata = 32'h0BADF00D; d_rem = 32'h44; d_quo = 32'h55;
    div_req = 1;
    step();
    mthi = 0; div_req = 0;
    checks++;
    if (hi !== 32'h0BADF00D || busy !== 1'b1) begin
      errors++; $display("FAIL wr_with_req: got hi=%h busy=%b expected 0badf00d 1", hi, busy);
    end
    for (int i = 0; i < 100 && busy; i++) step();
    checks++;
    if (hi !== 32'h44 || lo !== 32'h55 || done !== 1'b1) begin
      errors++; $display("FAIL wr_with_req_capture: got hi=%h lo=%h done=%b expected 44 55 1", hi, lo, done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_div("div_100_7", 32'd2, 32'd14);
    test_div("div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_div_zero();
    test_mult();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_write_busy();
    test_write_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
